// File: rtl/mem_wb_skid_if.sv
// MEM->WB stage bundle: mem-side inputs, write-port outputs and retire/occupancy status.
// The master drives the mem-side inputs; the slave is the pipeline register itself.
interface mem_wb_skid_if #(
  parameter int DATA_W     = 32,
  parameter int RADDR_W    = 5,
  parameter int CSR_ADDR_W = 12
);
  logic                  valid_in;
  logic                  ready_out;
  logic                  flush_in;
  logic                  stall_in;
  logic [DATA_W-1:0]     reg_wdata_in;
  logic [RADDR_W-1:0]    reg_waddr_in;
  logic                  reg_we_in;
  logic [DATA_W-1:0]     csr_wdata_in;
  logic [CSR_ADDR_W-1:0] csr_waddr_in;
  logic                  csr_we_in;
  logic                  valid_out;
  logic [DATA_W-1:0]     reg_wdata_out;
  logic [RADDR_W-1:0]    reg_waddr_out;
  logic                  reg_we_out;
  logic [DATA_W-1:0]     csr_wdata_out;
  logic [CSR_ADDR_W-1:0] csr_waddr_out;
  logic                  csr_we_out;
  logic                  instret_incr_out;
  logic [1:0]            occupancy_out;

  modport master (
    output valid_in, flush_in, stall_in,
    output reg_wdata_in, reg_waddr_in, reg_we_in,
    output csr_wdata_in, csr_waddr_in, csr_we_in,
    input  ready_out, valid_out,
    input  reg_wdata_out, reg_waddr_out, reg_we_out,
    input  csr_wdata_out, csr_waddr_out, csr_we_out,
    input  instret_incr_out, occupancy_out
  );

  modport slave (
    input  valid_in, flush_in, stall_in,
    input  reg_wdata_in, reg_waddr_in, reg_we_in,
    input  csr_wdata_in, csr_waddr_in, csr_we_in,
    output ready_out, valid_out,
    output reg_wdata_out, reg_waddr_out, reg_we_out,
    output csr_wdata_out, csr_waddr_out, csr_we_out,
    output instret_incr_out, occupancy_out
  );
endinterface

// File: rtl/mem_wb_skid.sv
// MEM->WB pipeline register with a one-entry skid buffer so ready toward MEM is registered.
// Carries GPR and CSR writeback fields and emits one instret pulse per retired instruction.
module mem_wb_skid #(
  parameter int DATA_W      = 32,
  parameter int RADDR_W     = 5,
  parameter int CSR_ADDR_W  = 12,
  parameter bit ZERO_REG_WE = 1'b0
) (
  input logic          clk_in,
  input logic          reset_n_in,
  mem_wb_skid_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0]     reg_wdata;
    logic [RADDR_W-1:0]    reg_waddr;
    logic                  reg_we;
    logic [DATA_W-1:0]     csr_wdata;
    logic [CSR_ADDR_W-1:0] csr_waddr;
    logic                  csr_we;
  } entry_t;

  // HALF: only OUT is live. FULL: OUT and SKID are both live, SKID being the younger.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;
  entry_t out_q;
  entry_t skid_q;
  entry_t in_entry;
  logic   accept;
  logic   load_out_in;
  logic   load_out_skid;
  logic   load_skid;
  logic   live;
  logic   valid_int;

  assign in_entry = '{
    reg_wdata: bus.reg_wdata_in,
    reg_waddr: bus.reg_waddr_in,
    reg_we:    bus.reg_we_in,
    csr_wdata: bus.csr_wdata_in,
    csr_waddr: bus.csr_waddr_in,
    csr_we:    bus.csr_we_in
  };

  assign accept = bus.valid_in & (state_q != FULL);

  always_comb begin
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (bus.flush_in) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            load_out_in = 1'b1;
            state_d     = HALF;
          end
        end
        HALF: begin
          if (bus.stall_in) begin
            if (accept) begin
              load_skid = 1'b1;
              state_d   = FULL;
            end
          end else if (accept) begin
            load_out_in = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (!bus.stall_in) begin
            load_out_skid = 1'b1;
            state_d       = HALF;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Payload registers are not cleared on flush; the valid state masks them instead.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out_in) begin
        out_q <= in_entry;
      end else if (load_out_skid) begin
        out_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  // While reset is held every output is forced idle, including the cycle it is first seen.
  assign live      = reset_n_in;
  assign valid_int = live & (state_q != EMPTY);

  assign bus.ready_out        = ~live | (state_q != FULL);
  assign bus.valid_out        = valid_int;
  assign bus.reg_wdata_out    = live ? out_q.reg_wdata : '0;
  assign bus.reg_waddr_out    = live ? out_q.reg_waddr : '0;
  assign bus.reg_we_out       = valid_int & out_q.reg_we & (ZERO_REG_WE | (out_q.reg_waddr != '0));
  assign bus.csr_wdata_out    = live ? out_q.csr_wdata : '0;
  assign bus.csr_waddr_out    = live ? out_q.csr_waddr : '0;
  assign bus.csr_we_out       = valid_int & out_q.csr_we;
  assign bus.instret_incr_out = valid_int & ~bus.stall_in & ~bus.flush_in;
  assign bus.occupancy_out    = !live          ? 2'd0 :
                                (state_q == FULL) ? 2'd2 :
                                (state_q == HALF) ? 2'd1 : 2'd0;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Randomised scoreboard bench for mem_wb_skid; two instances cover both ZERO_REG_WE settings.
// The reference model is a plain two-deep FIFO queue driven by the same stimulus.
module tb_mem_wb_skid;

  localparam int DATA_W     = 32;
  localparam int RADDR_W    = 5;
  localparam int CSR_ADDR_W = 12;

  typedef struct {
    logic [DATA_W-1:0]     reg_wdata;
    logic [RADDR_W-1:0]    reg_waddr;
    logic                  reg_we;
    logic [DATA_W-1:0]     csr_wdata;
    logic [CSR_ADDR_W-1:0] csr_waddr;
    logic                  csr_we;
  } entry_t;

  logic clk_in = 1'b0;
  logic reset_n_in;

  always #5 clk_in = ~clk_in;

  mem_wb_skid_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CSR_ADDR_W(CSR_ADDR_W)) bus0 ();
  mem_wb_skid_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CSR_ADDR_W(CSR_ADDR_W)) bus1 ();

  mem_wb_skid #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CSR_ADDR_W(CSR_ADDR_W),
                .ZERO_REG_WE(1'b0)) dut0 (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .bus(bus0));

  mem_wb_skid #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CSR_ADDR_W(CSR_ADDR_W),
                .ZERO_REG_WE(1'b1)) dut1 (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .bus(bus1));

  entry_t model_q[$];
  entry_t sb0[$];
  entry_t sb1[$];
  entry_t exp_front;
  entry_t pop0;
  entry_t pop1;
  entry_t idle_e;
  bit     got0;
  bit     got1;
  int     exp_occ;
  bit     tb_in_reset;
  bit     cur_stall;
  bit     cur_flush;
  int     n_checks;
  int     n_pass;

  function automatic entry_t mk(input logic [4:0] wa, input logic rwe, input logic [31:0] rwd,
                                input logic cwe, input logic [11:0] ca, input logic [31:0] cd);
    entry_t e;
    e.reg_wdata = rwd;
    e.reg_waddr = wa;
    e.reg_we    = rwe;
    e.csr_wdata = cd;
    e.csr_waddr = ca;
    e.csr_we    = cwe;
    return e;
  endfunction

  function automatic entry_t rand_entry();
    return mk(5'($urandom_range(0, 31)), 1'($urandom), $urandom,
              1'($urandom), 12'($urandom), $urandom);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_bus(input bit v, input bit st, input bit fl, input entry_t e);
    bus0.valid_in     = v;            bus1.valid_in     = v;
    bus0.stall_in     = st;           bus1.stall_in     = st;
    bus0.flush_in     = fl;           bus1.flush_in     = fl;
    bus0.reg_wdata_in = e.reg_wdata;  bus1.reg_wdata_in = e.reg_wdata;
    bus0.reg_waddr_in = e.reg_waddr;  bus1.reg_waddr_in = e.reg_waddr;
    bus0.reg_we_in    = e.reg_we;     bus1.reg_we_in    = e.reg_we;
    bus0.csr_wdata_in = e.csr_wdata;  bus1.csr_wdata_in = e.csr_wdata;
    bus0.csr_waddr_in = e.csr_waddr;  bus1.csr_waddr_in = e.csr_waddr;
    bus0.csr_we_in    = e.csr_we;     bus1.csr_we_in    = e.csr_we;
  endtask

  // One cycle of stimulus; the model decides what is live now and what retires this cycle.
  task automatic apply_stimulus(input bit v, input bit st, input bit fl, input bit rn,
                                input entry_t e);
    bit acc;
    @(posedge clk_in);
    #1;
    reset_n_in = rn;
    drive_bus(v, st, fl, e);
    cur_stall = st;
    cur_flush = fl;
    if (!rn) begin
      tb_in_reset = 1'b1;
      exp_occ     = 0;
      model_q.delete();
    end else begin
      tb_in_reset = 1'b0;
      exp_occ     = model_q.size();
      if (exp_occ > 0) exp_front = model_q[0];
      if (fl) begin
        model_q.delete();
      end else begin
        acc = v && (model_q.size() < 2);
        if (!st && model_q.size() > 0) begin
          sb0.push_back(model_q[0]);
          sb1.push_back(model_q[0]);
          void'(model_q.pop_front());
        end
        if (acc) model_q.push_back(e);
      end
    end
  endtask

  task automatic check_bus(input string tag, input bit zre, input logic vo, input logic ro,
                           input logic [1:0] occ, input logic ir, input logic rwe,
                           input logic cwe, input logic [31:0] rwd, input logic [4:0] rwa,
                           input logic [31:0] cwd, input logic [11:0] cwa,
                           input bit popped, input entry_t sb_e);
    if (tb_in_reset) begin
      check_output({tag, "_reset_valid"}, vo, 0);
      check_output({tag, "_reset_ready"}, ro, 1);
      check_output({tag, "_reset_occ"}, occ, 0);
      check_output({tag, "_reset_instret"}, ir, 0);
      check_output({tag, "_reset_we"}, {rwe, cwe}, 0);
      check_output({tag, "_reset_data"}, rwd | cwd | rwa | cwa, 0);
    end else begin
      check_output({tag, "_occ"}, occ, exp_occ);
      check_output({tag, "_ready"}, ro, exp_occ < 2);
      check_output({tag, "_valid"}, vo, exp_occ > 0);
      check_output({tag, "_instret"}, ir, (exp_occ > 0) && !cur_stall && !cur_flush);
      if (exp_occ > 0) begin
        check_output({tag, "_reg_we"}, rwe,
                     exp_front.reg_we && (zre || exp_front.reg_waddr != 0));
        check_output({tag, "_csr_we"}, cwe, exp_front.csr_we);
        check_output({tag, "_reg_waddr"}, rwa, exp_front.reg_waddr);
        check_output({tag, "_reg_wdata"}, rwd, exp_front.reg_wdata);
        check_output({tag, "_csr_waddr"}, cwa, exp_front.csr_waddr);
        check_output({tag, "_csr_wdata"}, cwd, exp_front.csr_wdata);
      end else begin
        check_output({tag, "_idle_we"}, {rwe, cwe}, 0);
      end
    end
    if (popped) begin
      check_output({tag, "_sb_waddr"}, rwa, sb_e.reg_waddr);
      check_output({tag, "_sb_wdata"}, rwd, sb_e.reg_wdata);
      check_output({tag, "_sb_csr"}, {cwe, cwa}, {sb_e.csr_we, sb_e.csr_waddr});
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT reports a retirement.
  always @(negedge clk_in) begin
    got0 = 1'b0;
    got1 = 1'b0;
    if (bus0.instret_incr_out) begin
      check_output("dut0_sb_avail", sb0.size() > 0, 1);
      if (sb0.size() > 0) begin pop0 = sb0.pop_front(); got0 = 1'b1; end
    end
    if (bus1.instret_incr_out) begin
      check_output("dut1_sb_avail", sb1.size() > 0, 1);
      if (sb1.size() > 0) begin pop1 = sb1.pop_front(); got1 = 1'b1; end
    end
    check_bus("dut0", 1'b0, bus0.valid_out, bus0.ready_out, bus0.occupancy_out,
              bus0.instret_incr_out, bus0.reg_we_out, bus0.csr_we_out, bus0.reg_wdata_out,
              bus0.reg_waddr_out, bus0.csr_wdata_out, bus0.csr_waddr_out, got0, pop0);
    check_bus("dut1", 1'b1, bus1.valid_out, bus1.ready_out, bus1.occupancy_out,
              bus1.instret_incr_out, bus1.reg_we_out, bus1.csr_we_out, bus1.reg_wdata_out,
              bus1.reg_waddr_out, bus1.csr_wdata_out, bus1.csr_waddr_out, got1, pop1);
  end

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    exp_occ     = 0;
    tb_in_reset = 1'b1;
    cur_stall   = 1'b0;
    cur_flush   = 1'b0;
    idle_e      = mk(5'd0, 1'b0, 32'd0, 1'b0, 12'd0, 32'd0);
    exp_front   = idle_e;
    pop0        = idle_e;
    pop1        = idle_e;
    reset_n_in  = 1'b0;
    drive_bus(1'b0, 1'b0, 1'b0, idle_e);

    repeat (3) apply_stimulus(0, 0, 0, 0, idle_e);

    // Unstalled stream of four writes.
    for (int i = 1; i <= 4; i++)
      apply_stimulus(1, 0, 0, 1, mk(5'(i), 1'b1, 32'h100 + 32'(i), 1'b0, 12'h0, 32'h0));
    repeat (2) apply_stimulus(0, 0, 0, 1, idle_e);

    // Backpressure: fill under stall, attempt a fourth while full, then drain.
    for (int i = 1; i <= 3; i++)
      apply_stimulus(1, 1, 0, 1, mk(5'(i), 1'b1, 32'h200 + 32'(i), 1'b0, 12'h0, 32'h0));
    apply_stimulus(1, 1, 0, 1, mk(5'd9, 1'b1, 32'h2FF, 1'b0, 12'h0, 32'h0));
    repeat (4) apply_stimulus(0, 0, 0, 1, idle_e);

    // Write to x0.
    apply_stimulus(1, 0, 0, 1, mk(5'd0, 1'b1, 32'hDEAD, 1'b0, 12'h0, 32'h0));
    repeat (2) apply_stimulus(0, 0, 0, 1, idle_e);

    // Flush while full with a new instruction arriving.
    apply_stimulus(1, 1, 0, 1, mk(5'd7, 1'b1, 32'h71, 1'b0, 12'h0, 32'h0));
    apply_stimulus(1, 1, 0, 1, mk(5'd8, 1'b1, 32'h81, 1'b0, 12'h0, 32'h0));
    apply_stimulus(1, 1, 1, 1, mk(5'd9, 1'b1, 32'h91, 1'b0, 12'h0, 32'h0));
    repeat (2) apply_stimulus(0, 0, 0, 1, idle_e);

    // CSR write held by one stall cycle before retiring.
    apply_stimulus(1, 0, 0, 1, mk(5'd3, 1'b0, 32'h0, 1'b1, 12'h300, 32'h8));
    apply_stimulus(0, 1, 0, 1, idle_e);
    repeat (2) apply_stimulus(0, 0, 0, 1, idle_e);

    // Reset while full and stalled, then one normal instruction.
    apply_stimulus(1, 1, 0, 1, mk(5'd4, 1'b1, 32'h41, 1'b0, 12'h0, 32'h0));
    apply_stimulus(1, 1, 0, 1, mk(5'd5, 1'b1, 32'h51, 1'b0, 12'h0, 32'h0));
    apply_stimulus(0, 1, 0, 0, idle_e);
    apply_stimulus(0, 0, 0, 0, idle_e);
    apply_stimulus(1, 0, 0, 1, mk(5'd6, 1'b1, 32'h61, 1'b1, 12'h301, 32'h62));
    repeat (2) apply_stimulus(0, 0, 0, 1, idle_e);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++)
      apply_stimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
                     $urandom_range(0, 19) == 0, $urandom_range(0, 99) != 0, rand_entry());
    repeat (4) apply_stimulus(0, 0, 0, 1, idle_e);

    @(posedge clk_in);
    #1;
    check_output("dut0_sb_drained", sb0.size(), 0);
    check_output("dut1_sb_drained", sb1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
